// File: rtl/wb_conmax_pri_arb.sv
// Priority arbiter for one wb_conmax slave port: level collapse, round-robin
// within the top requesting level, registered one-hot grant held until release.
// Optional owner hold limit: define WB_CONMAX_ARB_TIMEOUT_EN.
module wb_conmax_pri_arb #(
    parameter int N_MST       = 8,
    parameter int IDX_W       = 3,
    parameter int PRI_LEVELS  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_MST-1:0]   req_i,
    input  logic [2*N_MST-1:0] pri_i,
    output logic [N_MST-1:0]   gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    // Handshake: a master raises req_i[k] and keeps it high for as long as it
    // wants the slave; gnt_o[k] is the registered answer and stays set until
    // the master drops req_i[k] (or, with the hold limit, until it expires).
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [N_MST-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [1:0]         lvl [N_MST];
    logic [1:0]         max_lvl;
    logic [N_MST-1:0]   cand;
    logic [N_MST-1:0]   elig;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               owner_req;
    logic               timeout_fire;
    logic               new_grant;

    assign owner_req = |(req_i & gnt_q);

`ifdef WB_CONMAX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    assign timeout_fire = (state_q == ST_BUSY) && owner_req &&
                          (hold_cnt_q >= 8'(TIMEOUT_CYC - 1)) &&
                          (|(req_i & ~gnt_q));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant) begin
            hold_cnt_d = 8'd0;
        end else if (state_q == ST_BUSY && hold_cnt_q < 8'(TIMEOUT_CYC - 1)) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_fire       = 1'b0;
`endif

    // A timed-out owner sits out exactly one arbitration, whatever its level.
    assign cand = timeout_fire ? (req_i & ~gnt_q) : req_i;

    always_comb begin
        max_lvl = 2'd0;
        for (int k = 0; k < N_MST; k++) begin
            if (PRI_LEVELS == 1) begin
                lvl[k] = 2'd0;
            end else if (PRI_LEVELS == 2) begin
                lvl[k] = {1'b0, |pri_i[2*k +: 2]};
            end else begin
                lvl[k] = pri_i[2*k +: 2];
            end
            if (cand[k] && lvl[k] > max_lvl) begin
                max_lvl = lvl[k];
            end
        end
        for (int k = 0; k < N_MST; k++) begin
            elig[k] = cand[k] && (lvl[k] == max_lvl);
        end
    end

    always_comb begin : p_pick
        int scan;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= N_MST; i++) begin
            scan = int'(rr_ptr_q) + i;
            if (scan >= N_MST) begin
                scan = scan - N_MST;
            end
            if (!win_found && elig[scan]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        new_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    new_grant = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!owner_req || timeout_fire) begin
                    if (|cand) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (new_grant && win_found) begin
            state_d   = ST_BUSY;
            gnt_d     = {{(N_MST-1){1'b0}}, 1'b1} << win_idx;
            gnt_idx_d = win_idx;
            rr_ptr_d  = win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IDX_W'(N_MST - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign gnt_vld_o = (state_q == ST_BUSY);

endmodule

// File: doc/wb_conmax_pri_arb.md
# wb_conmax_pri_arb

Parametrised priority arbiter for the wb_conmax slave port. It takes the request and 2-bit priority of every master on a slave port. It collapses priorities to 1, 2 or 4 levels, then picks a winner by round-robin within the highest requesting level. The winner's one-hot grant is registered and held until that master releases its request. It replaces the per-master combinational priority decode plus fixed arbiter with a single sequential block that scales in master count.

## Interface
- N_MST, 8, number of masters; 2..16.
- IDX_W, 3, width of gnt_idx_o; must equal ceil(log2(N_MST)).
- PRI_LEVELS, 4, priority levels; legal values 1, 2, 4.
- TIMEOUT_CYC, 64, maximum hold cycles before forced re-arbitration; used only with WB_CONMAX_ARB_TIMEOUT_EN; 2..255.
- clk_i  in  1  clock, all state changes on rising edge.
- rst_ni  in  1  reset; one clock; asynchronous assert, active-low.
- req_i  in  N_MST  request per master (master cyc & stb for this slave).
- pri_i  in  2*N_MST  priority of master k is pri_i[2k+1:2k].
- gnt_o  out  N_MST  registered one-hot grant; all-zero when idle.
- gnt_idx_o  out  IDX_W  binary index of the granted master; holds the last value when idle.
- gnt_vld_o  out  1  high when gnt_o is non-zero.

## Operation
- Level mapping per master:
  - PRI_LEVELS=1: level 0 for every master.
  - PRI_LEVELS=2: level 0 if pri==0, else level 1.
  - PRI_LEVELS=4: level = pri.
- Eligible set: requesting masters whose level equals the maximum level among all requesting masters.
- Winner: the first eligible master scanning upward from (rr_ptr+1) mod N_MST, wrapping. rr_ptr is the index of the last granted master.
- States:
  - IDLE (gnt_vld_o=0): if any req_i bit is high, go to BUSY and register the winner. Otherwise stay.
  - BUSY: hold the grant while req_i[gnt_idx_o] is high.
    - If the owner's request drops and other requests exist, register the new winner directly in the same edge; no idle cycle.
    - If no requests remain, go to IDLE.
- rr_ptr updates to the winner index on every new grant; only grants update it.
- A higher-level request arriving during BUSY never preempts. It wins at the next arbitration.
- pri_i is sampled only at an arbitration edge. Priority changes by the owner during BUSY have no effect.
- Reset values: gnt_o=0, gnt_vld_o=0, gnt_idx_o=0, rr_ptr=N_MST-1 (so master 0 wins first on ties), state IDLE, hold counter 0.
- Reset mid-grant clears the grant immediately, asynchronously. The first arbitration after release follows the reset-value rules.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. req_i sampled at edge n gives gnt_o valid after edge n.
- Release-to-handover: 1 cycle. The owner's req low at edge n gives the new gnt_o after edge n.
- Grant outputs come straight from flops; the block adds no combinational path to its outputs.
- The combinational winner logic must meet a single cycle for N_MST=16.

## Configuration
- WB_CONMAX_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC-1 and at least one other master requests, the next edge re-arbitrates. The current owner is excluded from the eligible set for that one arbitration, even if it is of higher level.
  - If no other master requests, the grant stays and the counter saturates.
- Not defined: no counter logic exists; the grant is held until the owner releases, without limit.

## Test plan
- Reset then req_i=8'h00 -> gnt_vld_o=0, gnt_o=0, gnt_idx_o=0 indefinitely.
- PRI_LEVELS=4: req_i=8'h0A, master1 pri=1, master3 pri=3 -> one cycle later gnt_o=8'h08, gnt_idx_o=3. Drop req3 -> next cycle gnt_o=8'h02.
- PRI_LEVELS=2: masters 2 and 5 at pri=2 and 3 (both level 1), master 0 at pri=0, all held requesting and each released after one grant cycle -> grant order 2, 5, 2, 5, …; master 0 is never granted while either stays active.
- PRI_LEVELS=1: req_i=8'hFF, each owner releases after one cycle -> gnt_idx_o sequence 0,1,…,7,0 with gnt_vld_o constantly high.
- Owner 4 is granted. Master 6 at higher priority asserts mid-hold -> gnt_o stays 8'h10 until req4 drops, then 8'h40 on the next cycle.
- With WB_CONMAX_ARB_TIMEOUT_EN, TIMEOUT_CYC=4: master 0 holds, master 1 requests at the same level -> grant moves to master 1 after 4 BUSY cycles. The same test without the macro -> grant stays at master 0.
- Assert rst_ni mid-grant -> gnt_o=0 asynchronously. Release with req_i=8'h81 -> gnt_o=8'h01 one cycle later.
